// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } sa_state_t;

    function automatic int kw_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage operand delay line; DEPTH=0 degenerates to a wire.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk | rst;
            assign q = d;
        end else begin : g_shift
            logic [DW-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned s = 0; s < DEPTH; s++) begin
                        stage[s] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int unsigned s = 1; s < DEPTH; s++) begin
                        stage[s] <= stage[s-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an N x N MAC grid: clear, feed K skewed operand slices, drain, flag result.
// Optional completed-job counter port perf_jobs when SA_PERF_CNT_EN is defined.
module systolic_array_ctrl
    import sa_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int K  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   buf_rd_en,
    output logic [kw_width(K)-1:0] k_addr,
    input  logic [N*DW-1:0]        a_col,
    input  logic [N*DW-1:0]        b_row,
    output logic [N*DW-1:0]        a_feed,
    output logic [N*DW-1:0]        b_feed,
    output logic                   pe_clr_n,
    output logic                   res_valid
`ifdef SA_PERF_CNT_EN
    ,
    output logic [31:0]            perf_jobs
`endif
);

    localparam int KW  = kw_width(K);
    localparam int DL  = drain_len(N);
    localparam int DCW = kw_width(DL);
    localparam logic [KW-1:0]  K_LAST = KW'(K - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DL - 1);

    sa_state_t      state;
    sa_state_t      state_nxt;
    logic [KW-1:0]  k_cnt;
    logic [DCW-1:0] d_cnt;
    logic           rd_q;
    logic           clr_state;
    logic [N*DW-1:0] a_head;
    logic [N*DW-1:0] b_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        buf_rd_en = 1'b0;
        res_valid = 1'b0;
        clr_state = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_state = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                buf_rd_en = 1'b1;
                if (k_cnt == K_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (d_cnt == D_LAST) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Clear is also forced while reset is held so the PEs never see stale sums.
    assign pe_clr_n = rst & ~clr_state;
    assign k_addr   = k_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_cnt <= '0;
            d_cnt <= '0;
            rd_q  <= 1'b0;
        end else begin
            rd_q <= buf_rd_en;
            if (state == FEED) begin
                k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
            end
            if (state == DRAIN) begin
                d_cnt <= (d_cnt == D_LAST) ? '0 : d_cnt + 1'b1;
            end
        end
    end

    // Buffer data is only meaningful the cycle after a read strobe.
    assign a_head = rd_q ? a_col : '0;
    assign b_head = rd_q ? b_row : '0;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            sa_skew_line #(
                .DEPTH (i),
                .DW    (DW)
            ) u_a_skew (
                .clk (clk),
                .rst (rst),
                .d   (a_head[i*DW +: DW]),
                .q   (a_feed[i*DW +: DW])
            );

            sa_skew_line #(
                .DEPTH (i),
                .DW    (DW)
            ) u_b_skew (
                .clk (clk),
                .rst (rst),
                .d   (b_head[i*DW +: DW]),
                .q   (b_feed[i*DW +: DW])
            );
        end
    endgenerate

`ifdef SA_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_jobs <= '0;
        end else if (res_valid) begin
            perf_jobs <= perf_jobs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a buffer model and a behavioural MAC grid.
module tb_systolic_array_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int K  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          buf_rd_en;
    logic [1:0]    k_addr;
    logic [31:0]   a_col;
    logic [31:0]   b_row;
    logic [31:0]   a_feed;
    logic [31:0]   b_feed;
    logic          pe_clr_n;
    logic          res_valid;
`ifdef SA_PERF_CNT_EN
    logic [31:0]   perf_jobs;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;
    logic ff_mode = 1'b0;

    always #5 clk = ~clk;

    systolic_array_ctrl #(.N(N), .DW(DW), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .buf_rd_en (buf_rd_en),
        .k_addr    (k_addr),
        .a_col     (a_col),
        .b_row     (b_row),
        .a_feed    (a_feed),
        .b_feed    (b_feed),
        .pe_clr_n  (pe_clr_n),
        .res_valid (res_valid)
`ifdef SA_PERF_CNT_EN
        ,
        .perf_jobs (perf_jobs)
`endif
    );

    // A = identity, B[k][j] = k*4 + j + 1
    function automatic int a_elem(input int i, input int k);
        return (i == k) ? 1 : 0;
    endfunction

    function automatic int b_elem(input int k, input int j);
        return k * 4 + j + 1;
    endfunction

    // Operand buffer: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        if (ff_mode) begin
            a_col <= '1;
            b_row <= '1;
        end else if (buf_rd_en) begin
            for (int i = 0; i < N; i++) begin
                a_col[i*8 +: 8] <= 8'(a_elem(i, int'(k_addr)));
                b_row[i*8 +: 8] <= 8'(b_elem(int'(k_addr), i));
            end
        end else begin
            a_col <= 32'h5A5A5A5A;
            b_row <= 32'hA5A5A5A5;
        end
    end

    // Behavioural output-stationary MAC grid
    logic [7:0] pa [N][N];
    logic [7:0] pb [N][N];
    int         acc [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                automatic logic [7:0] ai = (j == 0) ? a_feed[i*8 +: 8] : pa[i][j-1];
                automatic logic [7:0] bi = (i == 0) ? b_feed[j*8 +: 8] : pb[i-1][j];
                pa[i][j] <= ai;
                pb[i][j] <= bi;
                if (!pe_clr_n) acc[i][j] <= 0;
                else           acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
            end
        end
    end

    typedef struct {
        logic        start;
        logic        busy;
        logic        rd;
        logic [1:0]  k;
        logic        clr_n;
        logic        rv;
        logic [31:0] af;
        logic [31:0] bf;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_rd"},     32'(buf_rd_en), 32'd0);
        chk({tag, "_kaddr"},  32'(k_addr),    32'd0);
        chk({tag, "_afeed"},  a_feed,         32'd0);
        chk({tag, "_bfeed"},  b_feed,         32'd0);
        chk({tag, "_rv"},     32'(res_valid), 32'd0);
        chk({tag, "_clrn"},   32'(pe_clr_n),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        int rv_at [4];
        int clr_cnt;

        rst   = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        chk_reset_outs("init");
        rst = 1'b1;
        tick();

        // Single job, table driven; entry e observed e+1 cycles after start edge
        for (int e = 0; e < 14; e++) begin
            automatic int t = e + 1;
            tv[e].start = (t == 1);
            tv[e].busy  = (t <= 13);
            tv[e].rd    = (t >= 2 && t <= 5);
            tv[e].k     = tv[e].rd ? 2'(t - 2) : 2'd0;
            tv[e].clr_n = (t != 1);
            tv[e].rv    = (t == 13);
            tv[e].af    = '0;
            tv[e].bf    = '0;
            for (int i = 0; i < N; i++) begin
                automatic int kk = t - 3 - i;
                if (kk >= 0 && kk < K) begin
                    tv[e].af[i*8 +: 8] = 8'(a_elem(i, kk));
                    tv[e].bf[i*8 +: 8] = 8'(b_elem(kk, i));
                end
            end
        end

        do_reset();
        for (int e = 0; e < 14; e++) begin
            start = tv[e].start;
            tick();
            chk($sformatf("job_busy_t%0d", e + 1),  32'(busy),      32'(tv[e].busy));
            chk($sformatf("job_rd_t%0d", e + 1),    32'(buf_rd_en), 32'(tv[e].rd));
            chk($sformatf("job_kaddr_t%0d", e + 1), 32'(k_addr),    32'(tv[e].k));
            chk($sformatf("job_clrn_t%0d", e + 1),  32'(pe_clr_n),  32'(tv[e].clr_n));
            chk($sformatf("job_rv_t%0d", e + 1),    32'(res_valid), 32'(tv[e].rv));
            chk($sformatf("job_afeed_t%0d", e + 1), a_feed,         tv[e].af);
            chk($sformatf("job_bfeed_t%0d", e + 1), b_feed,         tv[e].bf);
            if (e == 12) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        chk($sformatf("pe_c_%0d_%0d", i, j), 32'(acc[i][j]), 32'(b_elem(i, j)));
                    end
                end
            end
        end
        start = 1'b0;

        // Zero-fill window with a constant all-ones buffer
        do_reset();
        ff_mode = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 2; t <= 20; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                automatic logic [7:0] exp = (t >= 3 + i && t <= 2 + i + K) ? 8'hFF : 8'h00;
                chk($sformatf("skew_a_l%0d_t%0d", i, t), 32'(a_feed[i*8 +: 8]), 32'(exp));
                chk($sformatf("skew_b_l%0d_t%0d", i, t), 32'(b_feed[i*8 +: 8]), 32'(exp));
            end
        end
        ff_mode = 1'b0;

        // Asynchronous reset in the middle of FEED
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1 chk_reset_outs("midrst");
        tick();
        rst    = 1'b1;
        rv_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (res_valid) rv_cnt++;
        end
        chk("midrst_no_rv", 32'(rv_cnt), 32'd0);

        // start pulses during FEED and DRAIN are ignored
        do_reset();
        start = 1'b1;
        tick();
        rv_cnt   = 0;
        rv_at[0] = -1;
        for (int t = 2; t <= 30; t++) begin
            start = (t == 4 || t == 9);
            tick();
            if (res_valid) begin
                if (rv_cnt < 4) rv_at[rv_cnt] = t;
                rv_cnt++;
            end
        end
        start = 1'b0;
        chk("busy_start_rv_count", 32'(rv_cnt),   32'd1);
        chk("busy_start_rv_time",  32'(rv_at[0]), 32'd13);
        chk("busy_start_idle",     32'(busy),     32'd0);

        // start held high: jobs back to back, 14-cycle cadence
        do_reset();
        rv_cnt  = 0;
        clr_cnt = 0;
        for (int i = 0; i < 4; i++) rv_at[i] = -1;
        for (int t = 1; t <= 60; t++) begin
            start = (t <= 40);
            tick();
            if (res_valid) begin
                if (rv_cnt < 4) rv_at[rv_cnt] = t;
                rv_cnt++;
            end
            if (!pe_clr_n) clr_cnt++;
        end
        start = 1'b0;
        chk("b2b_rv_count",  32'(rv_cnt),   32'd3);
        chk("b2b_rv_first",  32'(rv_at[0]), 32'd13);
        chk("b2b_rv_second", 32'(rv_at[1]), 32'd27);
        chk("b2b_rv_third",  32'(rv_at[2]), 32'd41);
        chk("b2b_clr_count", 32'(clr_cnt),  32'd3);

`ifdef SA_PERF_CNT_EN
        do_reset();
        chk("perf_reset", perf_jobs, 32'd0);
        for (int j = 0; j < 3; j++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (14) tick();
        end
        chk("perf_three", perf_jobs, 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("perf_mid4th", perf_jobs, 32'd3);
        #2 rst = 1'b0;
        #1 chk("perf_after_rst", perf_jobs, 32'd0);
        tick();
        rst = 1'b1;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
